eth_axis_rx_pkt_fifo: RTL and testbench
=======================================

ETH_AXIS_RX_PKT_FIFO -- requirements
Module: eth_axis_rx_pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 512, AXIS tdata width in bits (multiple of 64); tkeep width is DATA_WIDTH/8.
REQ-002 Parameter TUSER_WIDTH, default 8, RX tuser width in bits.
REQ-003 Parameter DEPTH, default 512, buffer depth in beats (power of 2, >= 16).
REQ-004 Parameter ERR_BIT, default 0, tuser bit index flagging a bad packet (FCS/MAC error).
REQ-005 Parameter DROP_ON_ERR, default 1; 1 = discard errored packets, 0 = forward them with tuser intact.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 s_tvalid / s_tdata / s_tkeep / s_tlast / s_tuser  input  1/DATA_WIDTH/DATA_WIDTH/8/1/TUSER_WIDTH  RX stream from MAC; no backpressure exists.
REQ-009 m_tvalid / m_tdata / m_tkeep / m_tlast / m_tuser  output  1/DATA_WIDTH/DATA_WIDTH/8/1/TUSER_WIDTH  stream to client.
REQ-010 m_tready  input  1  client ready.
REQ-011 occupancy  output  $clog2(DEPTH)+1  beats written and not yet read, committed or not.
REQ-012 pkt_cnt / drop_err_cnt / drop_ovf_cnt  output  16 each  forwarded, error-dropped, overflow-dropped packet counters.

Function
REQ-013 Store-and-forward: no beat of a packet SHALL appear on m_* before that packet's tlast beat is written and committed.
REQ-014 Write side SHALL be an FSM with states IDLE (no packet in progress), ACCEPT (writing), DISCARD (dropping until tlast).
REQ-015 IDLE->ACCEPT on s_tvalid with space; tlast in the same beat commits a single-beat packet and stays in IDLE.
REQ-016 ACCEPT: each beat is written at wr_ptr; on tlast without drop, commit_ptr <= wr_ptr+1, pkt_cnt++, return to IDLE.
REQ-017 Error drop: DROP_ON_ERR=1 and s_tuser[ERR_BIT]=1 on the tlast beat -> wr_ptr rewinds to commit_ptr, drop_err_cnt++, IDLE.
REQ-018 Overflow: s_tvalid while the buffer is full (wr_ptr-rd_ptr==DEPTH) -> wr_ptr rewinds to commit_ptr, drop_ovf_cnt++, go to DISCARD (or IDLE if that beat has tlast).
REQ-019 DISCARD: ignore beats; on tlast go to IDLE; no counter changes.
REQ-020 Packets longer than DEPTH beats SHALL always be dropped through REQ-018.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full/empty are decided by the MSB compare.
REQ-022 Read side: data SHALL be valid when rd_ptr != commit_ptr; m_* SHALL be registered outputs behind a 2-entry skid so that m_tready=0 stalls without losing beats.
REQ-023 Latency: empty FIFO, tlast written at cycle T, m_tready=1 -> m_tvalid=1 at T+2 with the first beat; after that, one beat per cycle.
REQ-024 m_* SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-025 Simultaneous commit and read in the same cycle SHALL be lossless; a rewind SHALL never move wr_ptr below commit_ptr or affect committed beats.
REQ-026 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-027 With rst_n=0 at a clk edge: all pointers 0, FSM IDLE, counters 0, m_tvalid=0, occupancy=0; m_tdata/m_tkeep/m_tuser/m_tlast=0.
REQ-028 Reset mid-packet SHALL discard all buffered and partial data; the first beat after reset release is treated as a packet start.
REQ-029 Memory contents need no reset.

Structure
REQ-030 The FSM state enum and the counter width constant SHALL be in ofs_fim_eth_if_pkg; widths derive from parameters, not from package constants.
REQ-031 Storage SHALL be one sub-module, eth_pkt_fifo_ram: simple dual-port, one-cycle registered read, width DATA_WIDTH+DATA_WIDTH/8+TUSER_WIDTH+1.

Verification
REQ-032 Three 4-beat good packets back-to-back, m_tready=1 -> 12 beats out in order, pkt_cnt=3, first m_tvalid 2 cycles after the first tlast.
REQ-033 DROP_ON_ERR=1, 3-beat packet with tuser[ERR_BIT]=1 on tlast, then a 2-beat good packet -> only the 2-beat packet out, drop_err_cnt=1, pkt_cnt=1.
REQ-034 DEPTH=16, m_tready=0, 10-beat packet then 10-beat packet -> first kept, second dropped, drop_ovf_cnt=1; after release only 10 beats out.
REQ-035 m_tready toggled 1010... over a 6-beat packet -> all 6 beats out unchanged, no duplicates, tlast only on beat 6.
REQ-036 rst_n=0 for 1 cycle during beat 3 of 5, with a committed packet buffered -> m_tvalid=0, counters 0, nothing from either packet is output.
REQ-037 Pointer wrap: 100 random packets of 1-15 beats through DEPTH=16 with random m_tready -> scoreboard match; pkt_cnt+drop counts=100.

Source files
------------

// File: rtl/ofs_fim_eth_if_pkg.sv
// Shared types and constants for the Ethernet RX packet FIFO slice.
//   wr_state_e : write-side packet FSM states
//   CNT_W      : width of the packet statistics counters
//   sat_inc    : saturating increment for the statistics counters
package ofs_fim_eth_if_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_ACCEPT  = 2'd1,
    WR_DISCARD = 2'd2
  } wr_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_pkt_fifo_ram.sv
// Simple dual-port storage for the packet FIFO, one-cycle registered read.
//   clk        : single clock
//   i_wr_en    : write strobe, i_wr_addr / i_wr_data : write port
//   i_rd_en    : read strobe,  i_rd_addr             : read address
//   o_rd_data  : read data, valid the cycle after i_rd_en
module eth_pkt_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/eth_axis_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO between a MAC (no backpressure) and a client.
// A packet becomes visible to the read side only once its tlast beat has been
// written; errored packets (DROP_ON_ERR) and packets that run out of space are
// rewound away without touching committed data.
//   clk, rst_n         : clock, synchronous active-low reset
//   s_t*               : RX stream from the MAC
//   m_t*, m_tready     : registered stream to the client
//   occupancy          : beats written (committed or not) and not yet read from storage
//   pkt_cnt            : forwarded packets, drop_err_cnt / drop_ovf_cnt : dropped packets
module eth_axis_rx_pkt_fifo
  import ofs_fim_eth_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned TUSER_WIDTH = 8,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ERR_BIT     = 0,
  parameter int unsigned DROP_ON_ERR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_tvalid,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_tkeep,
  input  logic                       s_tlast,
  input  logic [TUSER_WIDTH-1:0]     s_tuser,
  output logic                       m_tvalid,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_tkeep,
  output logic                       m_tlast,
  output logic [TUSER_WIDTH-1:0]     m_tuser,
  input  logic                       m_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           drop_err_cnt,
  output logic [CNT_W-1:0]           drop_ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned MW = DATA_WIDTH + KW + TUSER_WIDTH + 1;

  logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
  wr_state_e     r_state, w_state_nxt;
  logic          w_full, w_is_err;
  logic          w_wr_en, w_commit, w_rewind;
  logic          w_inc_pkt, w_inc_err, w_inc_ovf;
  logic [MW-1:0] w_wr_word, w_ram_word;

  // ---------------- write side ----------------
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_is_err  = (DROP_ON_ERR != 0) && s_tuser[ERR_BIT];
  assign w_wr_word = {s_tuser, s_tlast, s_tkeep, s_tdata};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WR_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_inc_pkt   = 1'b0;
    w_inc_err   = 1'b0;
    w_inc_ovf   = 1'b0;
    case (r_state)
      WR_IDLE, WR_ACCEPT: begin
        if (s_tvalid) begin
          if (w_full) begin
            w_rewind    = 1'b1;
            w_inc_ovf   = 1'b1;
            w_state_nxt = s_tlast ? WR_IDLE : WR_DISCARD;
          end else begin
            w_wr_en = 1'b1;
            if (s_tlast) begin
              w_state_nxt = WR_IDLE;
              if (w_is_err) begin
                w_rewind  = 1'b1;
                w_inc_err = 1'b1;
              end else begin
                w_commit  = 1'b1;
                w_inc_pkt = 1'b1;
              end
            end else begin
              w_state_nxt = WR_ACCEPT;
            end
          end
        end
      end
      WR_DISCARD: if (s_tvalid && s_tlast) w_state_nxt = WR_IDLE;
      default:    w_state_nxt = WR_IDLE;
    endcase
  end

  // ---------------- read side ----------------
  // Output holding register (r_m_*) plus one skid entry (r_s_*). A storage read
  // is only issued when the beat it returns next cycle is guaranteed a slot.
  logic          r_ram_vld, r_m_vld, r_s_vld;
  logic [MW-1:0] r_m_word, r_s_word;
  logic          w_pop, w_rd_avail, w_rd_en;
  logic [1:0]    w_level;

  assign w_pop      = r_m_vld && m_tready;
  assign w_rd_avail = (r_rd_ptr != r_commit_ptr);
  assign w_level    = 2'(r_m_vld) + 2'(r_s_vld) + 2'(r_ram_vld);
  assign w_rd_en    = w_rd_avail && (w_level < (w_pop ? 2'd3 : 2'd2));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      pkt_cnt      <= '0;
      drop_err_cnt <= '0;
      drop_ovf_cnt <= '0;
    end else begin
      if (w_rewind)     r_wr_ptr <= r_commit_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_commit)     r_commit_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en)      r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_inc_pkt)    pkt_cnt      <= sat_inc(pkt_cnt);
      if (w_inc_err)    drop_err_cnt <= sat_inc(drop_err_cnt);
      if (w_inc_ovf)    drop_ovf_cnt <= sat_inc(drop_ovf_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ram_vld <= 1'b0;
      r_m_vld   <= 1'b0;
      r_s_vld   <= 1'b0;
      r_m_word  <= '0;
    end else begin
      r_ram_vld <= w_rd_en;
      if (w_pop || !r_m_vld) begin
        if (r_s_vld) begin
          r_m_word <= r_s_word;
          r_m_vld  <= 1'b1;
          r_s_vld  <= r_ram_vld;
          r_s_word <= w_ram_word;
        end else begin
          r_m_vld <= r_ram_vld;
          if (r_ram_vld) r_m_word <= w_ram_word;
        end
      end else if (r_ram_vld) begin
        r_s_vld  <= 1'b1;
        r_s_word <= w_ram_word;
      end
    end
  end

  eth_pkt_fifo_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en && rst_n),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_ram_word)
  );

  assign m_tvalid  = r_m_vld;
  assign m_tdata   = r_m_word[DATA_WIDTH-1:0];
  assign m_tkeep   = r_m_word[DATA_WIDTH +: KW];
  assign m_tlast   = r_m_word[DATA_WIDTH+KW];
  assign m_tuser   = r_m_word[MW-1 -: TUSER_WIDTH];
  assign occupancy = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_eth_axis_rx_pkt_fifo.sv
// Self-checking bench for eth_axis_rx_pkt_fifo (64-bit data, DEPTH=16).
// Sent packets are logged; a monitor logs every accepted output beat; a
// scoreboard then walks the sent packets in order and requires the output to
// be an in-order selection of whole, unmodified, non-errored packets.
module tb_eth_axis_rx_pkt_fifo;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned UW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_tvalid, s_tlast, m_tvalid, m_tlast, m_tready;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic [UW-1:0] s_tuser, m_tuser;
  logic [PW-1:0] occupancy;
  logic [15:0]   pkt_cnt, drop_err_cnt, drop_ovf_cnt;

  eth_axis_rx_pkt_fifo #(
    .DATA_WIDTH  (DW),
    .TUSER_WIDTH (UW),
    .DEPTH       (DEPTH),
    .ERR_BIT     (0),
    .DROP_ON_ERR (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tuser      (s_tuser),
    .m_tvalid     (m_tvalid),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .m_tready     (m_tready),
    .occupancy    (occupancy),
    .pkt_cnt      (pkt_cnt),
    .drop_err_cnt (drop_err_cnt),
    .drop_ovf_cnt (drop_ovf_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_assert = 0;
  int    n_fail = 0;
  int    rdy_mode = 3;  // 0: ready, 1: toggle, 2: random, 3: stalled
  int    pkt_id = 0;
  beat_t sent_q[$];
  int    pkt_start[$];
  int    pkt_len[$];
  bit    pkt_err[$];
  int    pkt_tlast_cyc[$];
  beat_t out_q[$];
  int    out_cyc[$];

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      out_q.push_back({m_tdata, m_tkeep, m_tlast, m_tuser});
      out_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      2:       m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic clear_logs();
    sent_q.delete(); pkt_start.delete(); pkt_len.delete(); pkt_err.delete();
    pkt_tlast_cyc.delete(); out_q.delete(); out_cyc.delete();
  endtask

  task automatic send_pkt(input int len, input bit err, input int gap_pct);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = {16'(pkt_id), 8'(b), 8'hC3, 32'($urandom)};
      bt.last = (b == len - 1);
      bt.keep = bt.last ? 8'($urandom_range(1, 255)) : 8'hFF;
      bt.user = 8'($urandom);
      if (bt.last) bt.user[0] = err;
      if (b == 0) begin
        pkt_start.push_back(sent_q.size());
        pkt_len.push_back(len);
        pkt_err.push_back(err);
      end
      sent_q.push_back(bt);
      s_tvalid = 1'b1; s_tdata = bt.data; s_tkeep = bt.keep;
      s_tlast = bt.last; s_tuser = bt.user;
      tick();
      if (bt.last) pkt_tlast_cyc.push_back(cyc);
      s_tvalid = 1'b0;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) tick();
    end
    pkt_id++;
  endtask

  task automatic drain(input string tag);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 4 && n < 3000) begin
      tick();
      n++;
      if (occupancy == '0 && !m_tvalid) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drain_done"}, 128'(quiet >= 4), 128'(1));
  endtask

  task automatic score(input string tag, output int matched, output int good_skip,
                       output int err_skip);
    int op;
    int s;
    op = 0; matched = 0; good_skip = 0; err_skip = 0;
    for (int i = 0; i < pkt_len.size(); i++) begin
      s = pkt_start[i];
      if (!pkt_err[i] && op < out_q.size() && out_q[op] === sent_q[s]) begin
        chk({tag, "_store_fwd_lat"}, 128'(out_cyc[op] >= pkt_tlast_cyc[i] + 2), 128'(1));
        for (int b = 0; b < pkt_len[i]; b++) begin
          chk({tag, "_beat_avail"}, 128'(op < out_q.size()), 128'(1));
          if (op < out_q.size()) chk({tag, "_beat"}, 128'(out_q[op]), 128'(sent_q[s + b]));
          op++;
        end
        matched++;
      end else if (pkt_err[i]) begin
        err_skip++;
      end else begin
        good_skip++;
      end
    end
    chk({tag, "_unexpected_beats"}, 128'(out_q.size() - op), 128'(0));
  endtask

  initial begin
    logic [15:0]  b_pkt, b_err, b_ovf;
    logic [127:0] snap;
    int           matched, good_skip, err_skip, n_err;

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    repeat (3) tick();
    chk("rst_m_tvalid",  128'(m_tvalid), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_pkt_cnt",   128'(pkt_cnt), 128'(0));
    chk("rst_err_cnt",   128'(drop_err_cnt), 128'(0));
    chk("rst_ovf_cnt",   128'(drop_ovf_cnt), 128'(0));
    chk("rst_m_tdata",   128'({m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(0));
    rst_n = 1'b1;
    tick();

    // three 4-beat good packets back to back
    clear_logs(); rdy_mode = 0; tick();
    b_pkt = pkt_cnt;
    repeat (3) send_pkt(4, 1'b0, 0);
    drain("t1");
    score("t1", matched, good_skip, err_skip);
    chk("t1_beats",   128'(out_q.size()), 128'(12));
    chk("t1_matched", 128'(matched), 128'(3));
    chk("t1_pkt_cnt", 128'(pkt_cnt - b_pkt), 128'(3));
    chk("t1_latency", 128'(out_cyc[0] - pkt_tlast_cyc[0]), 128'(2));

    // errored 3-beat packet, then good 2-beat packet
    clear_logs();
    b_pkt = pkt_cnt; b_err = drop_err_cnt; b_ovf = drop_ovf_cnt;
    send_pkt(3, 1'b1, 0);
    send_pkt(2, 1'b0, 0);
    drain("t2");
    score("t2", matched, good_skip, err_skip);
    chk("t2_matched", 128'(matched), 128'(1));
    chk("t2_beats",   128'(out_q.size()), 128'(2));
    chk("t2_err_cnt", 128'(drop_err_cnt - b_err), 128'(1));
    chk("t2_pkt_cnt", 128'(pkt_cnt - b_pkt), 128'(1));
    chk("t2_ovf_cnt", 128'(drop_ovf_cnt - b_ovf), 128'(0));

    // overflow: two 10-beat packets into 16 beats while stalled
    clear_logs(); rdy_mode = 3; tick();
    b_pkt = pkt_cnt; b_ovf = drop_ovf_cnt;
    send_pkt(10, 1'b0, 0);
    send_pkt(10, 1'b0, 0);
    repeat (4) tick();
    chk("t3_stall_valid", 128'(m_tvalid), 128'(1));
    chk("t3_stall_head",  128'(m_tdata), 128'(sent_q[0].data));
    snap = 128'({m_tdata, m_tkeep, m_tlast, m_tuser});
    repeat (5) tick();
    chk("t3_stall_stable", 128'({m_tdata, m_tkeep, m_tlast, m_tuser}), snap);
    chk("t3_ovf_cnt", 128'(drop_ovf_cnt - b_ovf), 128'(1));
    rdy_mode = 0;
    drain("t3");
    score("t3", matched, good_skip, err_skip);
    chk("t3_matched",   128'(matched), 128'(1));
    chk("t3_good_skip", 128'(good_skip), 128'(1));
    chk("t3_beats",     128'(out_q.size()), 128'(10));
    chk("t3_pkt_cnt",   128'(pkt_cnt - b_pkt), 128'(1));

    // ready toggling over a 6-beat packet
    clear_logs(); rdy_mode = 1;
    send_pkt(6, 1'b0, 0);
    drain("t4");
    score("t4", matched, good_skip, err_skip);
    chk("t4_matched", 128'(matched), 128'(1));
    chk("t4_beats",   128'(out_q.size()), 128'(6));

    // reset during beat 3 of 5 with a committed packet waiting
    clear_logs(); rdy_mode = 3; tick();
    send_pkt(2, 1'b0, 0);
    for (int b = 0; b < 3; b++) begin
      s_tvalid = 1'b1; s_tdata = {16'hDEAD, 8'(b), 40'h0}; s_tkeep = 8'hFF;
      s_tlast = 1'b0; s_tuser = '0;
      if (b == 2) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1; s_tvalid = 1'b0;
    chk("t5_m_tvalid",  128'(m_tvalid), 128'(0));
    chk("t5_m_word",    128'({m_tdata, m_tkeep, m_tlast, m_tuser}), 128'(0));
    chk("t5_occupancy", 128'(occupancy), 128'(0));
    chk("t5_pkt_cnt",   128'(pkt_cnt), 128'(0));
    chk("t5_err_cnt",   128'(drop_err_cnt), 128'(0));
    chk("t5_ovf_cnt",   128'(drop_ovf_cnt), 128'(0));
    clear_logs(); rdy_mode = 0;
    repeat (20) tick();
    chk("t5_no_output", 128'(out_q.size()), 128'(0));
    send_pkt(2, 1'b0, 0);
    drain("t5");
    score("t5", matched, good_skip, err_skip);
    chk("t5_matched", 128'(matched), 128'(1));
    chk("t5_pkt_cnt", 128'(pkt_cnt), 128'(1));

    // 100 random packets with random client readiness
    clear_logs(); rdy_mode = 2;
    b_pkt = pkt_cnt; b_err = drop_err_cnt; b_ovf = drop_ovf_cnt;
    n_err = 0;
    for (int p = 0; p < 100; p++) begin
      bit e;
      e = ($urandom_range(0, 4) == 0);
      if (e) n_err++;
      send_pkt($urandom_range(1, 15), e, 15);
      if ($urandom_range(0, 2) == 0) tick();
    end
    rdy_mode = 0;
    drain("t6");
    score("t6", matched, good_skip, err_skip);
    chk("t6_err_seen", 128'(err_skip), 128'(n_err));
    chk("t6_pkt_cnt",  128'(pkt_cnt - b_pkt), 128'(matched));
    chk("t6_ovf_cnt",  128'(drop_ovf_cnt - b_ovf),
        128'(good_skip + n_err - int'(drop_err_cnt - b_err)));
    chk("t6_total",    128'(int'(pkt_cnt - b_pkt) + int'(drop_err_cnt - b_err)
                            + int'(drop_ovf_cnt - b_ovf)), 128'(100));
    chk("t6_occupancy", 128'(occupancy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
